// File: rtl/commit_unit.sv
// In-order retirement stage: pops the completed ROB head, writes the arch RF, updates
// the retirement RAT and free list, and on a mispredicted branch flushes and replays the RAT.
module commit_unit #(
  parameter int ROB_ENTRY_SIZE = 192,
  parameter int ARCH_REGS      = 32
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      FREEZE,
  input  logic [ROB_ENTRY_SIZE-1:0] rob_data,
  input  logic                      rob_empty,
  output logic                      do_read,
  output logic                      rf_we,
  output logic [4:0]                rf_addr,
  output logic [63:0]               rf_data,
  output logic                      free_we,
  output logic [5:0]                free_preg,
  output logic                      mispredict,
  output logic [31:0]               redirect_pc,
  output logic                      rat_restore_we,
  output logic [4:0]                rat_restore_idx,
  output logic [5:0]                rat_restore_preg,
  output logic                      recovering,
  output logic [31:0]               commit_count
);

  typedef enum logic [1:0] {RUN, FLUSH, RECOVER} state_t;

  typedef struct packed {
    logic [31:0] hi;
    logic        done;
    logic        mp;
    logic        wb;
    logic [4:0]  arch;
    logic [5:0]  newp;
    logic [5:0]  oldp;
    logic [31:0] lo;
  } rob_fields_t;

  localparam logic [4:0] LAST_IDX = 5'(ARCH_REGS - 1);

  rob_fields_t e;
  state_t      state_q, state_d;
  logic [4:0]  walk_q, walk_d;
  logic [5:0]  rat_q [ARCH_REGS];
  logic        rf_q, free_q, mp_q;
  logic [31:0] cnt_q;
  logic        unused_rob_bits;

  assign e.hi   = rob_data[191:160];
  assign e.done = rob_data[153];
  assign e.mp   = rob_data[141];
  assign e.wb   = rob_data[140];
  assign e.arch = rob_data[139:135];
  assign e.newp = rob_data[133:128];
  assign e.oldp = rob_data[127:122];
  assign e.lo   = rob_data[95:64];

  assign unused_rob_bits = ^{rob_data[159:154], rob_data[152:142], rob_data[134],
                             rob_data[121:96], rob_data[63:0]};

  // Next-state and combinational outputs; FREEZE folds into every advance condition.
  always_comb begin
    state_d          = state_q;
    walk_d           = walk_q;
    do_read          = 1'b0;
    rat_restore_we   = 1'b0;
    rat_restore_idx  = '0;
    rat_restore_preg = '0;
    recovering       = (state_q != RUN);
    case (state_q)
      RUN: begin
        do_read = !FREEZE && !rob_empty && e.done;
        if (do_read && e.mp) state_d = FLUSH;
      end
      FLUSH: begin
        if (!FREEZE) begin
          state_d = RECOVER;
          walk_d  = '0;
        end
      end
      RECOVER: begin
        rat_restore_we   = !FREEZE;
        rat_restore_idx  = walk_q;
        rat_restore_preg = rat_q[walk_q];
        if (!FREEZE) begin
          walk_d = walk_q + 5'd1;
          if (walk_q == LAST_IDX) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= RUN;
      walk_q  <= '0;
    end else if (!FREEZE) begin
      state_q <= state_d;
      walk_q  <= walk_d;
    end
  end

  // Retirement RAT: identity after reset, written at each committing writeback.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < ARCH_REGS; i++) rat_q[i] <= 6'(i);
    end else if (do_read && e.wb) begin
      rat_q[e.arch] <= e.newp;
    end
  end

  // Pulse registers hold while frozen so a pending strobe surfaces on the first free cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rf_q        <= 1'b0;
      free_q      <= 1'b0;
      mp_q        <= 1'b0;
      rf_addr     <= '0;
      rf_data     <= '0;
      free_preg   <= '0;
      redirect_pc <= '0;
      cnt_q       <= '0;
    end else if (!FREEZE) begin
      rf_q   <= do_read && e.wb;
      free_q <= do_read && e.wb;
      mp_q   <= do_read && e.mp;
      if (do_read) begin
        cnt_q <= cnt_q + 32'd1;
        if (e.wb) begin
          rf_addr   <= e.arch;
          rf_data   <= {e.hi, e.lo};
          free_preg <= e.oldp;
        end
        if (e.mp) redirect_pc <= e.hi;
      end
    end
  end

  assign rf_we        = rf_q   && !FREEZE;
  assign free_we      = free_q && !FREEZE;
  assign mispredict   = mp_q   && !FREEZE;
  assign commit_count = cnt_q;

endmodule

// File: tb/tb_commit_unit.sv
// Bench for commit_unit: directed vector table, hand sequences for flush/freeze/reset/wrap,
// then random traffic checked every cycle against a counter-based reference model.
module tb_commit_unit;
  logic         CLK = 1'b0;
  logic         RESET, FREEZE, rob_empty;
  logic [191:0] rob_data;
  logic         do_read, rf_we, free_we, mispredict, rat_restore_we, recovering;
  logic [4:0]   rf_addr, rat_restore_idx;
  logic [63:0]  rf_data;
  logic [5:0]   free_preg, rat_restore_preg;
  logic [31:0]  redirect_pc, commit_count;

  commit_unit dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .rob_data(rob_data), .rob_empty(rob_empty),
    .do_read(do_read), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .free_we(free_we), .free_preg(free_preg), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .rat_restore_we(rat_restore_we),
    .rat_restore_idx(rat_restore_idx), .rat_restore_preg(rat_restore_preg),
    .recovering(recovering), .commit_count(commit_count)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [191:0] mk(bit done, bit wb, bit mp, logic [4:0] arch,
                                      logic [5:0] np, logic [5:0] op,
                                      logic [31:0] hi, logic [31:0] lo);
    logic [191:0] d;
    d = '0;
    d[191:160] = hi; d[153] = done; d[141] = mp; d[140] = wb;
    d[139:135] = arch; d[133:128] = np; d[127:122] = op; d[95:64] = lo;
    return d;
  endfunction

  // Reference model: blackout counts unfrozen cycles left in flush (33) + walk (32..1).
  logic [5:0]  m_rat [32];
  logic [31:0] m_cnt;
  int          m_blk;
  bit          p_rf, p_mp;
  logic [4:0]  p_addr;
  logic [63:0] p_data;
  logic [5:0]  p_free;
  logic [31:0] p_pc;

  function automatic bit m_pop();
    return !FREEZE && !rob_empty && rob_data[153] && (m_blk == 0);
  endfunction

  task automatic model_update();
    bit rd;
    rd = m_pop();
    if (RESET) begin
      for (int i = 0; i < 32; i++) m_rat[i] = 6'(i);
      m_cnt = 0; m_blk = 0; p_rf = 0; p_mp = 0;
    end else if (!FREEZE) begin
      if (m_blk > 0) m_blk--;
      p_rf = 0; p_mp = 0;
      if (rd) begin
        m_cnt = m_cnt + 1;
        if (rob_data[140]) begin
          p_rf = 1; p_addr = rob_data[139:135];
          p_data = {rob_data[191:160], rob_data[95:64]};
          p_free = rob_data[127:122];
          m_rat[rob_data[139:135]] = rob_data[133:128];
        end
        if (rob_data[141]) begin
          p_mp = 1; p_pc = rob_data[191:160]; m_blk = 33;
        end
      end
    end
  endtask

  task automatic check_model();
    bit exp_rw;
    int idx;
    chk("do_read", do_read, m_pop());
    chk("rf_we", rf_we, p_rf && !FREEZE);
    chk("free_we", free_we, p_rf && !FREEZE);
    if (p_rf && !FREEZE) begin
      chk("rf_addr", rf_addr, p_addr);
      chk("rf_data", rf_data, p_data);
      chk("free_preg", free_preg, p_free);
    end
    chk("mispredict", mispredict, p_mp && !FREEZE);
    if (p_mp && !FREEZE) chk("redirect_pc", redirect_pc, p_pc);
    chk("recovering", recovering, m_blk > 0);
    exp_rw = !FREEZE && m_blk >= 1 && m_blk <= 32;
    chk("rat_restore_we", rat_restore_we, exp_rw);
    if (exp_rw) begin
      idx = 32 - m_blk;
      chk("rat_restore_idx", rat_restore_idx, idx);
      chk("rat_restore_preg", rat_restore_preg, m_rat[idx]);
    end
    chk("commit_count", commit_count, m_cnt);
  endtask

  task automatic tick_check();
    @(negedge CLK);
    check_model();
  endtask

  task automatic tick_adv();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic walk_check(int p5);
    for (int k = 0; k < 32; k++) begin
      tick_check();
      chk("walk_we", rat_restore_we, 1);
      chk("walk_idx", rat_restore_idx, k);
      chk("walk_preg", rat_restore_preg, (k == 5) ? p5 : k);
      chk("walk_do_read", do_read, 0);
      tick_adv();
    end
  endtask

  typedef struct {
    bit          empty, done, wb;
    logic [4:0]  arch;
    logic [5:0]  np, op;
    logic [31:0] hi, lo;
    bit          e_rd, e_we;
    logic [31:0] e_cnt;
    logic [4:0]  e_addr;
    logic [63:0] e_data;
    logic [5:0]  e_free;
  } vec_t;

  vec_t tbl [10];

  initial begin
    bit found;
    logic [191:0] d;
    // empty done wb arch np op hi lo | rd we cnt addr data free
    tbl[0] = '{0,1,1,5,40,5,32'h1,32'h2, 1,0,0, 0,0,0};
    tbl[1] = '{1,1,1,3,3,3,0,0,          0,1,1, 5,64'h0000000100000002,5};
    tbl[2] = '{0,0,1,7,7,7,0,7,          0,0,1, 0,0,0};
    tbl[3] = '{0,0,1,7,7,7,0,7,          0,0,1, 0,0,0};
    tbl[4] = '{0,0,1,7,7,7,0,7,          0,0,1, 0,0,0};
    tbl[5] = '{0,1,1,7,7,20,0,7,         1,0,1, 0,0,0};
    tbl[6] = '{0,1,1,8,8,21,0,8,         1,1,2, 7,64'h7,20};
    tbl[7] = '{0,1,1,9,9,22,0,9,         1,1,3, 8,64'h8,21};
    tbl[8] = '{1,1,1,9,9,22,0,9,         0,1,4, 9,64'h9,22};
    tbl[9] = '{1,1,1,9,9,22,0,9,         0,0,4, 0,0,0};

    RESET = 1; FREEZE = 0; rob_empty = 1; rob_data = '0;
    @(posedge CLK); model_update(); #1;
    tick_check();
    chk("rst_rf_we", rf_we, 0); chk("rst_free_we", free_we, 0);
    chk("rst_mp", mispredict, 0); chk("rst_rec", recovering, 0);
    chk("rst_cnt", commit_count, 0); chk("rst_rw", rat_restore_we, 0);
    chk("rst_rf_data", rf_data, 0); chk("rst_pc", redirect_pc, 0);
    tick_adv();
    RESET = 0;

    // Basic commit, stall on not-done, back-to-back retirement
    foreach (tbl[i]) begin
      rob_empty = tbl[i].empty;
      rob_data  = mk(tbl[i].done, tbl[i].wb, 0, tbl[i].arch, tbl[i].np, tbl[i].op,
                     tbl[i].hi, tbl[i].lo);
      tick_check();
      chk("tbl_do_read", do_read, tbl[i].e_rd);
      chk("tbl_rf_we", rf_we, tbl[i].e_we);
      chk("tbl_free_we", free_we, tbl[i].e_we);
      chk("tbl_cnt", commit_count, tbl[i].e_cnt);
      if (tbl[i].e_we) begin
        chk("tbl_rf_addr", rf_addr, tbl[i].e_addr);
        chk("tbl_rf_data", rf_data, tbl[i].e_data);
        chk("tbl_free_preg", free_preg, tbl[i].e_free);
      end
      tick_adv();
    end

    // Mispredicted branch; a ready entry sits at the head during recovery and must be ignored
    rob_empty = 0;
    rob_data  = mk(1, 0, 1, 0, 0, 0, 32'h00400100, 0);
    tick_check(); chk("br_do_read", do_read, 1); tick_adv();
    rob_data  = mk(1, 1, 0, 3, 60, 61, 32'hDEAD, 32'hBEEF);
    tick_check();
    chk("br_mp", mispredict, 1); chk("br_pc", redirect_pc, 32'h00400100);
    chk("br_flush_rec", recovering, 1); chk("br_flush_rd", do_read, 0);
    chk("br_flush_rw", rat_restore_we, 0);
    tick_adv();
    walk_check(40);
    rob_empty = 1;
    tick_check(); chk("br_done_rec", recovering, 0); chk("br_mp_once", mispredict, 0);
    tick_adv();

    // FREEZE right after a mispredict commit defers the pulse
    rob_empty = 0; rob_data = mk(1, 0, 1, 0, 0, 0, 32'h1234, 0);
    tick_check(); tick_adv();
    rob_empty = 1; FREEZE = 1;
    for (int i = 0; i < 3; i++) begin
      tick_check(); chk("frz_mp", mispredict, 0); chk("frz_cnt", commit_count, 6);
      tick_adv();
    end
    FREEZE = 0;
    tick_check(); chk("unfrz_mp", mispredict, 1); chk("unfrz_pc", redirect_pc, 32'h1234);
    tick_adv();
    walk_check(40);

    // RESET mid-walk
    rob_empty = 0; rob_data = mk(1, 0, 1, 0, 0, 0, 32'hABCD0000, 0);
    tick_check(); tick_adv();
    rob_empty = 1;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick_check();
      if (rat_restore_we && rat_restore_idx == 5'd12) found = 1;
      else tick_adv();
    end
    if (!found) chk("wait_idx12", 0, 1);
    RESET = 1; tick_adv(); RESET = 0;
    tick_check();
    chk("mid_rst_rec", recovering, 0); chk("mid_rst_cnt", commit_count, 0);
    chk("mid_rst_rw", rat_restore_we, 0); chk("mid_rst_mp", mispredict, 0);
    chk("mid_rst_rf", rf_we, 0);
    tick_adv();
    rob_empty = 0; rob_data = mk(1, 0, 1, 0, 0, 0, 32'h55, 0);
    tick_check(); tick_adv();
    rob_empty = 1;
    tick_check(); tick_adv();
    walk_check(5);

    // Counter wrap
    FREEZE = 1;
    force dut.cnt_q = 32'hFFFFFFFF;
    tick_adv();
    release dut.cnt_q;
    m_cnt = 32'hFFFFFFFF;
    tick_check(); chk("wrap_pre", commit_count, 32'hFFFFFFFF); tick_adv();
    FREEZE = 0; rob_empty = 0; rob_data = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tick_check(); tick_adv();
    rob_empty = 1;
    tick_check(); chk("wrap", commit_count, 0); tick_adv();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      RESET     = ($urandom_range(0, 199) == 0);
      FREEZE    = ($urandom_range(0, 9) == 0);
      rob_empty = ($urandom_range(0, 4) == 0);
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      d[153] = ($urandom_range(0, 9) < 7);
      d[141] = ($urandom_range(0, 99) < 3);
      d[140] = ($urandom_range(0, 9) < 7);
      rob_data = d;
      tick_check();
      tick_adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/commit_unit.md
Name: commit_unit

Overview:
In-order retirement stage directly downstream of the 64-entry reorder buffer.
- Each cycle it inspects the ROB head entry. If that entry has completed, it retires it:
  - pops the head;
  - writes the architectural register file;
  - updates the retirement RAT;
  - returns the superseded physical register to the free list.
- On a retired mispredicted branch it flushes the machine, redirects fetch, and streams the retirement RAT back to the front-end RAT.

Parameters:
ROB_ENTRY_SIZE, 192, width of a ROB entry
ARCH_REGS, 32, architectural registers (retirement RAT depth and recovery walk length)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous active-high reset
FREEZE  in  1  global stall; block holds all state, drives do_read=0 and all write strobes 0
rob_data  in  192  ROB head entry (combinational from ROB)
rob_empty  in  1  ROB empty flag
do_read  out  1  pop ROB head this cycle (combinational)
rf_we  out  1  arch register file write strobe (registered)
rf_addr  out  5  arch destination register
rf_data  out  64  {result_hi, result_lo}
free_we  out  1  free-list push strobe (registered)
free_preg  out  6  physical register returned to free list
mispredict  out  1  one-cycle flush pulse to ROB/rename/issue (registered)
redirect_pc  out  32  fetch redirect target, valid with mispredict
rat_restore_we  out  1  front-end RAT restore strobe
rat_restore_idx  out  5  arch register being restored
rat_restore_preg  out  6  retirement mapping for rat_restore_idx
recovering  out  1  high in FLUSH and RECOVER states
commit_count  out  32  retired-instruction counter, wraps at 2^32

Behaviour:
ROB entry fields used:
- [191:160] result_hi; for branches, the redirect target.
- [153] done.
- [141] mispredict flag.
- [140] writeback enable.
- [139:135] arch dest.
- [133:128] new phys dest.
- [127:122] old phys dest.
- [95:64] result_lo.

State machine: RUN, FLUSH, RECOVER.

Reset (RESET=1 at posedge), regardless of state:
- State goes to RUN.
- All outputs 0; commit_count=0.
- Retirement RAT entry i = i, for i = 0..31.

RUN state:
- Commit condition: do_read = !FREEZE && !rob_empty && rob_data[153]. It depends only on current inputs; no bubble is required between commits.
- Throughput: at most one retirement per cycle.
- On a commit posedge:
  - commit_count increments.
  - If bit 140=1: next cycle rf_we=1 with rf_addr = arch dest and rf_data = {result_hi, result_lo}. In the same cycle free_we=1 with free_preg = old phys dest. Retirement RAT[arch dest] <= new phys dest.
  - If bit 140=0: no rf, free or RAT action.
  - If bit 141=1: the branch itself still retires. Next cycle mispredict=1 for exactly one cycle and redirect_pc = result_hi. State goes to FLUSH.
- Strobes rf_we, free_we and mispredict are single-cycle pulses, low in every cycle not following a commit.

FLUSH state (1 cycle):
- do_read=0; recovering=1.
- Next state: RECOVER, with walk index = 0.

RECOVER state:
- Each cycle: rat_restore_we=1, rat_restore_idx = index, rat_restore_preg = RAT[index]; index then increments.
- After index 31 is emitted, next state is RUN. The walk is exactly 32 cycles.
- do_read=0 throughout; recovering=1.
- The ROB is empty after the mispredict flush, so any non-empty rob_data seen here is ignored.

FREEZE:
- Freezes the state, walk index, RAT and counter.
- Forces do_read, rf_we, free_we and rat_restore_we to 0 during the frozen cycle.
- A pending mispredict pulse is deferred until the first unfrozen cycle, not dropped.

Other boundaries:
- Entry not done (bit 153=0) → stall, no pop.
- rob_empty=1 → no pop, even if rob_data[153]=1.
- RESET during RECOVER aborts the walk immediately.
- commit_count: 0xFFFFFFFF + 1 = 0.

Test Plan:
1. Reset, then push an entry {done=1, wb=1, arch=5, new=40, old=5, hi=0x1, lo=0x2} → do_read=1 same cycle. Next cycle: rf_we=1, rf_addr=5, rf_data=0x0000000100000002, free_we=1, free_preg=5, commit_count=1.
2. Head entry with done=0 for 3 cycles, then done=1 → do_read stays 0 for 3 cycles and pops on the 4th. Back-to-back ready entries retire one per cycle with no bubble.
3. Retire a branch {done=1, wb=0, mispredict=1, hi=0x00400100} → mispredict pulse of 1 cycle with redirect_pc=0x00400100, then 1 FLUSH cycle and 32 RECOVER cycles. Restore stream shows idx 5 → preg 40 and all others identity; do_read=0 throughout.
4. FREEZE asserted in the cycle after a mispredicted-branch commit → mispredict held off. It pulses in the first cycle after FREEZE drops; the commit count is unchanged while frozen.
5. RESET asserted mid-RECOVER (idx=12) → next cycle state RUN, all strobes 0, RAT identity, commit_count=0.
6. Preload commit_count=0xFFFFFFFF via 2^32 commits (or a force) and retire one more → commit_count=0.
